mem_load_unit: RTL and testbench

//  Load-side data-memory port of the pipeline: the read direction of the store-merge path.

---
 rtl/mem_load_unit_pkg.sv | 18 +
 rtl/mem_load_unit_extract.sv | 39 +++
 rtl/mem_load_unit.sv | 142 ++++++++++++++
 tb/tb_mem_load_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_unit_pkg.sv
// Shared width codes, FSM state encoding and alignment helper for the load unit.
package mem_load_unit_pkg;

    localparam logic [1:0] WB_BYTE = 2'b00;
    localparam logic [1:0] WB_HEX  = 2'b01;
    localparam logic [1:0] WB_WORD = 2'b10;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_WAIT = 2'b01,
        LD_DONE = 2'b10
    } ld_state_e;

    function automatic logic misaligned(input logic [1:0] op, input logic [1:0] sel);
        return ((op == WB_HEX) && sel[0]) || ((op == WB_WORD) && (sel != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_unit_extract.sv
// Combinational byte/half/word lane select with sign/zero extension (mirror of store merge).
module load_extract
    import mem_load_unit_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [1:0]  sel_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        byte_s = rdata_i[7:0];
        case (sel_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase

        half_s = rdata_i[15:0];
        case (sel_i)
            2'b00:   half_s = rdata_i[15:0];
            2'b01:   half_s = rdata_i[23:8];
            default: half_s = rdata_i[31:16];
        endcase

        result_o = rdata_i;
        case (op_i)
            WB_BYTE: result_o = {{24{~unsigned_i & byte_s[7]}}, byte_s};
            WB_HEX:  result_o = {{16{~unsigned_i & half_s[15]}}, half_s};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Single-outstanding load port: aligned DRAM read, ack timeout, lane extraction.
// Optional LOAD_MISALIGN_TRAP_EN: misaligned HEX/WORD loads complete at once with ld_err.
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_op,
    input  logic        ld_unsigned,
    output logic        dram_req,
    output logic [31:0] dram_addr,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata,
    output logic        ld_done,
    output logic        ld_err,
    output logic [31:0] ld_data,
    output logic        stall
);

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        op_q, op_d;
    logic              uns_q, uns_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;
    logic              ready_q, ready_d;
    logic              trap;
    logic [31:0]       extracted;

    load_extract u_extract (
        .op_i       (op_q),
        .sel_i      (sel_q),
        .unsigned_i (uns_q),
        .rdata_i    (dram_rdata),
        .result_o   (extracted)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        op_d    = op_q;
        uns_d   = uns_q;
        req_d   = req_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        trap    = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        trap    = misaligned(ld_op, ld_addr[1:0]);
`endif

        case (state_q)
            LD_IDLE: begin
                if (ld_valid && ready_q) begin
                    sel_d = ld_addr[1:0];
                    op_d  = ld_op;
                    uns_d = ld_unsigned;
                    cnt_d = '0;
                    if (trap) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else begin
                        state_d = LD_WAIT;
                        req_d   = 1'b1;
                        addr_d  = {ld_addr[31:2], 2'b00};
                    end
                end
            end
            LD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ack takes priority over the timeout in the same cycle.
                if (dram_ack) begin
                    state_d = LD_DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    data_d  = extracted;
                end else if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = LD_DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    data_d  = '0;
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase

        ready_d = (state_d == LD_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            op_q    <= '0;
            uns_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            uns_q   <= uns_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign ld_ready  = ready_q;
    assign stall     = ~ready_q;
    assign dram_req  = req_q;
    assign dram_addr = addr_q;
    assign ld_done   = done_q;
    assign ld_err    = err_q;
    assign ld_data   = data_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Table-driven load vectors through a completion scoreboard, plus timeout/reset sequences.
module tb_mem_load_unit;
    import mem_load_unit_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_op = '0;
    logic        ld_unsigned = 1'b0;
    logic        dram_req;
    logic [31:0] dram_addr;
    logic        dram_ack = 1'b0;
    logic [31:0] dram_rdata = '0;
    logic        ld_done;
    logic        ld_err;
    logic [31:0] ld_data;
    logic        stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  op;
        logic        uns;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    logic prev_done = 1'b0;

    mem_load_unit #(.ACK_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_op       (ld_op),
        .ld_unsigned (ld_unsigned),
        .dram_req    (dram_req),
        .dram_addr   (dram_addr),
        .dram_ack    (dram_ack),
        .dram_rdata  (dram_rdata),
        .ld_done     (ld_done),
        .ld_err      (ld_err),
        .ld_data     (ld_data),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic trap_exp(input logic [1:0] op, input logic [31:0] addr);
`ifdef LOAD_MISALIGN_TRAP_EN
        return misaligned(op, addr[1:0]);
`else
        return 1'b0;
`endif
    endfunction

    // Completion scoreboard: every ld_done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ld_done) begin
                chk("done_one_cycle", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ld_data", ld_data, e.data);
                    chk("ld_err", 32'(ld_err), 32'(e.err));
                end
            end
            prev_done = ld_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ld_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (ld_ready !== 1'b1) chk("ready_timeout", 32'(ld_ready), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("completion_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // ack_wait < 0: never acknowledge (timeout path).
    task automatic run_load(input logic [31:0] addr, input logic [1:0] op, input logic uns,
                            input logic [31:0] rdata, input int ack_wait, input logic [31:0] exp);
        logic trap;
        exp_t e;
        int n;
        trap = trap_exp(op, addr);
        e.err  = trap || (ack_wait < 0);
        e.data = e.err ? 32'h0 : exp;
        wait_ready();
        ld_valid = 1'b1; ld_addr = addr; ld_op = op; ld_unsigned = uns;
        sb.push_back(e);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        if (trap) begin
            chk("trap_no_req", 32'(dram_req), 32'd0);
            chk("trap_done", 32'(ld_done), 32'd1);
        end else begin
            chk("dram_req", 32'(dram_req), 32'd1);
            chk("dram_addr", dram_addr, {addr[31:2], 2'b00});
            chk("stall", 32'(stall), 32'd1);
            if (ack_wait < 0) begin
                n = 0;
                while (dram_req === 1'b1 && n < 40) begin
                    n++;
                    @(posedge clk); #1;
                end
                chk("timeout_req_cycles", n, TO);
                chk("timeout_done", 32'(ld_done & ld_err), 32'd1);
            end else begin
                for (int i = 0; i < ack_wait; i++) begin
                    @(posedge clk); #1;
                    chk("stall_wait", 32'(stall), 32'd1);
                end
                dram_ack = 1'b1; dram_rdata = rdata;
                @(posedge clk); #1;
                dram_ack = 1'b0;
                chk("done_after_ack", 32'(ld_done), 32'd1);
                chk("req_drop", 32'(dram_req), 32'd0);
            end
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;

        vecs.push_back('{32'h0000_0000, WB_BYTE, 1'b0, 32'h8040_20F1, 32'hFFFF_FFF1});
        vecs.push_back('{32'h0000_0003, WB_BYTE, 1'b1, 32'h8040_20F1, 32'h0000_0080});
        vecs.push_back('{32'h0000_0001, WB_HEX,  1'b0, 32'h8040_20F1, 32'h0000_4020});
        vecs.push_back('{32'h0000_0002, WB_HEX,  1'b0, 32'h8040_20F1, 32'hFFFF_8040});
        vecs.push_back('{32'h0000_0001, WB_BYTE, 1'b0, 32'h8040_20F1, 32'h0000_0020});
        vecs.push_back('{32'h0000_0002, WB_BYTE, 1'b0, 32'h8040_20F1, 32'h0000_0040});
        vecs.push_back('{32'h0000_0003, WB_BYTE, 1'b0, 32'h8040_20F1, 32'hFFFF_FF80});
        vecs.push_back('{32'h0000_0000, WB_BYTE, 1'b1, 32'h8040_20F1, 32'h0000_00F1});
        vecs.push_back('{32'h0000_0000, WB_HEX,  1'b0, 32'h8040_20F1, 32'h0000_20F1});
        vecs.push_back('{32'h0000_0003, WB_HEX,  1'b1, 32'h8040_20F1, 32'h0000_8040});
        vecs.push_back('{32'h0000_0003, WB_HEX,  1'b0, 32'h8040_20F1, 32'hFFFF_8040});
        vecs.push_back('{32'h0000_0002, WB_WORD, 1'b1, 32'h8040_20F1, 32'h8040_20F1});
        vecs.push_back('{32'h0000_0001, 2'b11,   1'b1, 32'h8040_20F1, 32'h8040_20F1});
        vecs.push_back('{32'hA000_0101, WB_HEX,  1'b0, 32'h7F80_01FE, 32'hFFFF_8001});
        vecs.push_back('{32'hA000_0104, WB_BYTE, 1'b1, 32'h7F80_01FE, 32'h0000_00FE});
        vecs.push_back('{32'hA000_0104, WB_BYTE, 1'b0, 32'h7F80_01FE, 32'hFFFF_FFFE});
        vecs.push_back('{32'hA000_0106, WB_HEX,  1'b0, 32'h7F80_01FE, 32'h0000_7F80});
        vecs.push_back('{32'hA000_0105, WB_BYTE, 1'b0, 32'h7F80_01FE, 32'h0000_0001});

        // Reset state
        #12;
        chk("rst_ready", 32'(ld_ready), 32'd1);
        chk("rst_req", 32'(dram_req), 32'd0);
        chk("rst_done", 32'(ld_done), 32'd0);
        chk("rst_err", 32'(ld_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_addr", dram_addr, 32'h0);
        chk("rst_data", ld_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ack while idle is ignored
        dram_ack = 1'b1; dram_rdata = 32'hDEAD_BEEF;
        repeat (2) begin @(posedge clk); #1; end
        dram_ack = 1'b0;
        chk("idle_ack_done", 32'(ld_done), 32'd0);
        chk("idle_ack_ready", 32'(ld_ready), 32'd1);
        chk("idle_ack_data", ld_data, 32'h0);

        foreach (vecs[i])
            run_load(vecs[i].addr, vecs[i].op, vecs[i].uns, vecs[i].rdata, i % 3, vecs[i].exp);

        // ld_data holds after completion
        repeat (3) begin @(posedge clk); #1; end
        chk("data_hold", ld_data, trap_exp(WB_BYTE, 32'hA000_0105) ? 32'h0 : 32'h0000_0001);

        // Misaligned word, ack after 4 wait cycles
        run_load(32'h1000_0007, WB_WORD, 1'b0, 32'h1234_5678, 4, 32'h1234_5678);

        // Timeout, then ack exactly on the timeout cycle
        run_load(32'h0000_0040, WB_WORD, 1'b0, 32'h5555_AAAA, -1, 32'h0);
        run_load(32'h0000_0044, WB_WORD, 1'b0, 32'h5555_AAAA, TO - 1, 32'h5555_AAAA);

        // Reset mid-load: request abandoned, no completion
        wait_ready();
        ld_valid = 1'b1; ld_addr = 32'h0000_0020; ld_op = WB_BYTE; ld_unsigned = 1'b0;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(dram_req), 32'd0);
        chk("midrst_ready", 32'(ld_ready), 32'd1);
        chk("midrst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (ld_done) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        run_load(32'h0000_0022, WB_HEX, 1'b1, 32'hC3C3_9696, 0, 32'h0000_C3C3);

        // Misaligned HEX: trapped when the macro is on, extracted otherwise
        run_load(32'h0000_0301, WB_HEX, 1'b0, 32'h0011_2233, 1, 32'h0000_1122);

        repeat (3) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
